hold_ctrl: RTL and testbench

HOLD_CTRL -- requirements
Module: hold_ctrl

---
 rtl/hold_ctrl_pkg.sv | 31 +++
 rtl/hold_ctrl_if.sv | 45 ++++
 rtl/hold_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_hold_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hold_ctrl_pkg.sv
// Shared definitions for the pipeline hold / redirect controller.
// Holds the hold-level encodings, bus widths, the FSM state encoding and a
// small helper to merge hold levels.
package hold_ctrl_pkg;

  localparam int HOLD_FLAG_BUS = 3;
  localparam int INST_ADDR_BUS = 32;
  localparam int CNT_W         = 3;

  // Pipeline hold levels; a larger value stalls more stages.
  localparam logic [HOLD_FLAG_BUS-1:0] HOLD_NONE = 3'd0;
  localparam logic [HOLD_FLAG_BUS-1:0] HOLD_PC   = 3'd1;
  localparam logic [HOLD_FLAG_BUS-1:0] HOLD_IF   = 3'd2;
  localparam logic [HOLD_FLAG_BUS-1:0] HOLD_ID   = 3'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2,
    ST_RESET = 2'd3
  } state_e;

  // Hold levels are ordered, so the merged request is simply the larger one.
  function automatic logic [HOLD_FLAG_BUS-1:0] hold_max(
    input logic [HOLD_FLAG_BUS-1:0] a,
    input logic [HOLD_FLAG_BUS-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hold_ctrl_if.sv
// Signal bundle between the pipeline/debug sources and hold_ctrl.
// master : the pipeline side (drives requests, observes hold/redirect)
// slave  : hold_ctrl itself
//   ex_jump_req_i/ex_jump_addr_i : EX branch taken + target
//   ex_hold_req_i, bus_hold_req_i : level stall requests
//   jtag_halt_req_i, jtag_reset_req_i : debugger halt / core reset
//   int_req_i/int_addr_i : interrupt request + handler address
//   jump_flag_o/jump_addr_o : PC redirect, hold_flag_o : hold level
//   flush_o : IF/ID NOP inject, int_ack_o : interrupt taken pulse
//   jtag_halted_o : core halted, jtag_reset_flag_o : force reset PC
interface hold_ctrl_if;
  import hold_ctrl_pkg::*;

  logic                     ex_jump_req_i;
  logic [INST_ADDR_BUS-1:0] ex_jump_addr_i;
  logic                     ex_hold_req_i;
  logic                     bus_hold_req_i;
  logic                     jtag_halt_req_i;
  logic                     jtag_reset_req_i;
  logic                     int_req_i;
  logic [INST_ADDR_BUS-1:0] int_addr_i;

  logic                     jump_flag_o;
  logic [INST_ADDR_BUS-1:0] jump_addr_o;
  logic [HOLD_FLAG_BUS-1:0] hold_flag_o;
  logic                     flush_o;
  logic                     int_ack_o;
  logic                     jtag_halted_o;
  logic                     jtag_reset_flag_o;

  modport master (
    output ex_jump_req_i, ex_jump_addr_i, ex_hold_req_i, bus_hold_req_i,
           jtag_halt_req_i, jtag_reset_req_i, int_req_i, int_addr_i,
    input  jump_flag_o, jump_addr_o, hold_flag_o, flush_o, int_ack_o,
           jtag_halted_o, jtag_reset_flag_o
  );

  modport slave (
    input  ex_jump_req_i, ex_jump_addr_i, ex_hold_req_i, bus_hold_req_i,
           jtag_halt_req_i, jtag_reset_req_i, int_req_i, int_addr_i,
    output jump_flag_o, jump_addr_o, hold_flag_o, flush_o, int_ack_o,
           jtag_halted_o, jtag_reset_flag_o
  );

endinterface

// File: rtl/hold_ctrl.sv
// hold_ctrl: pipeline hold, flush and PC-redirect controller.
// Arbitrates EX jumps, interrupts, debugger halt/reset and stall requests.
// Redirect, hold level and interrupt acknowledge are combinational so the PC
// register sees them with zero latency; state, counters and the halted flag
// are registered.
// Ports:
//   clk : core clock (rising edge)
//   rst : asynchronous active-high reset
//   hc  : hold_ctrl_if.slave bundle (requests in, hold/redirect out)
// Parameters:
//   FLUSH_CYCLES : IF/ID bubble cycles after a redirect (1..7)
//   RST_CYCLES   : cycles jtag_reset_flag_o stays asserted (1..7)
module hold_ctrl
  import hold_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned RST_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        rst,
  hold_ctrl_if.slave  hc
);

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LOAD   = CNT_W'(RST_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     int_pend_q, int_pend_d;
  logic [INST_ADDR_BUS-1:0] int_vec_q, int_vec_d;
  logic                     jtag_rst_q, jtag_rst_d;
  logic                     halted_q, halted_d;

  logic                     rst_edge_s;
  logic                     int_take_s;
  logic                     jump_take_s;
  logic [HOLD_FLAG_BUS-1:0] hold_base_s;

  logic                     jump_flag_s;
  logic [INST_ADDR_BUS-1:0] jump_addr_s;
  logic [HOLD_FLAG_BUS-1:0] hold_s;
  logic                     flush_s;
  logic                     int_ack_s;

  // Arbitration: which redirect (if any) wins this cycle in RUN.
  always_comb begin
    rst_edge_s = hc.jtag_reset_req_i & ~jtag_rst_q;
    if ((state_q == ST_RUN) && !rst_edge_s) begin
      // An interrupt waits for EX to finish and then pre-empts the EX jump.
      int_take_s  = (int_pend_q | hc.int_req_i) & ~hc.ex_hold_req_i;
      jump_take_s = hc.ex_jump_req_i & ~int_take_s;
    end else begin
      int_take_s  = 1'b0;
      jump_take_s = 1'b0;
    end
  end

  // Next-state, counter and interrupt bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (rst_edge_s) begin
      // A debugger reset edge wins in every state and restarts the count.
      state_d = ST_RESET;
      cnt_d   = RST_LOAD;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (int_take_s || jump_take_s) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_LOAD;
          end else if (hc.jtag_halt_req_i) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (cnt_q == 3'd0) begin
            state_d = hc.jtag_halt_req_i ? ST_HALT : ST_RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        ST_HALT: begin
          if (hc.jtag_halt_req_i) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_RESET: begin
          if (cnt_q == 3'd0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 3'd0;
        end
      endcase
    end

    // A core reset discards any pending interrupt; otherwise the request
    // stays pending until the cycle it is acknowledged.
    if (rst_edge_s || (state_q == ST_RESET)) begin
      int_pend_d = 1'b0;
    end else if (int_take_s) begin
      int_pend_d = 1'b0;
    end else if (hc.int_req_i) begin
      int_pend_d = 1'b1;
    end else begin
      int_pend_d = int_pend_q;
    end

    int_vec_d  = hc.int_req_i ? hc.int_addr_i : int_vec_q;
    jtag_rst_d = hc.jtag_reset_req_i;
    halted_d   = (state_d == ST_HALT);
  end

  // Output decode; forced to zero while rst is asserted.
  always_comb begin
    case (state_q)
      ST_RUN: begin
        if (int_take_s || jump_take_s) begin
          hold_base_s = HOLD_NONE;
        end else if (hc.ex_hold_req_i) begin
          hold_base_s = HOLD_ID;
        end else begin
          hold_base_s = HOLD_NONE;
        end
      end
      ST_FLUSH: hold_base_s = HOLD_NONE;
      ST_HALT:  hold_base_s = HOLD_ID;
      ST_RESET: hold_base_s = HOLD_ID;
      default:  hold_base_s = HOLD_ID;
    endcase

    if (rst) begin
      jump_flag_s = 1'b0;
      jump_addr_s = 32'd0;
      hold_s      = HOLD_NONE;
      flush_s     = 1'b0;
      int_ack_s   = 1'b0;
    end else begin
      jump_flag_s = int_take_s | jump_take_s;
      if (int_take_s) begin
        // A request arriving this cycle carries the freshest handler address.
        jump_addr_s = hc.int_req_i ? hc.int_addr_i : int_vec_q;
      end else if (jump_take_s) begin
        jump_addr_s = hc.ex_jump_addr_i;
      end else begin
        jump_addr_s = 32'd0;
      end
      int_ack_s = int_take_s;
      // The reset-edge cycle already stalls and flushes ahead of RESET.
      flush_s   = int_take_s | jump_take_s | rst_edge_s |
                  (state_q == ST_FLUSH) | (state_q == ST_RESET);
      hold_s    = hold_max(rst_edge_s ? HOLD_ID : hold_base_s,
                           hc.bus_hold_req_i ? HOLD_PC : HOLD_NONE);
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= 3'd0;
      int_pend_q <= 1'b0;
      int_vec_q  <= 32'd0;
      jtag_rst_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      int_pend_q <= int_pend_d;
      int_vec_q  <= int_vec_d;
      jtag_rst_q <= jtag_rst_d;
      halted_q   <= halted_d;
    end
  end

  assign hc.jump_flag_o       = jump_flag_s;
  assign hc.jump_addr_o       = jump_addr_s;
  assign hc.hold_flag_o       = hold_s;
  assign hc.flush_o           = flush_s;
  assign hc.int_ack_o         = int_ack_s;
  assign hc.jtag_halted_o     = halted_q;
  assign hc.jtag_reset_flag_o = (state_q == ST_RESET);

endmodule

// File: tb/tb_hold_ctrl.sv
// Self-checking bench for hold_ctrl (FLUSH_CYCLES=2, RST_CYCLES=2).
// Each cycle's expected outputs are queued when the stimulus is driven and
// compared on the following falling edge.
module tb_hold_ctrl;
  import hold_ctrl_pkg::*;

  typedef struct packed {
    logic        jf;
    logic [31:0] ja;
    logic [2:0]  hf;
    logic        fl;
    logic        ack;
    logic        hlt;
    logic        rf;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  mon_e;
  string mon_tag;

  hold_ctrl_if hcif();

  hold_ctrl #(.FLUSH_CYCLES(2), .RST_CYCLES(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .hc  (hcif)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive all request inputs.
  task automatic drv(input logic jr, input logic [31:0] ja, input logic eh, input logic bh,
                     input logic hr, input logic jrr, input logic ir, input logic [31:0] ia);
    hcif.ex_jump_req_i    = jr;
    hcif.ex_jump_addr_i   = ja;
    hcif.ex_hold_req_i    = eh;
    hcif.bus_hold_req_i   = bh;
    hcif.jtag_halt_req_i  = hr;
    hcif.jtag_reset_req_i = jrr;
    hcif.int_req_i        = ir;
    hcif.int_addr_i       = ia;
  endtask

  task automatic idle();
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Queue the expected outputs for the current cycle, then advance one cycle.
  task automatic step(input string tag, input logic jf, input logic [31:0] ja, input logic [2:0] hf,
                      input logic fl, input logic ack, input logic hlt, input logic rf);
    exp_t e;
    e.jf = jf; e.ja = ja; e.hf = hf; e.fl = fl; e.ack = ack; e.hlt = hlt; e.rf = rf;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: compare each queued expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e   = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      check_val({mon_tag, ".jump_flag"},  32'(hcif.jump_flag_o),       32'(mon_e.jf));
      check_val({mon_tag, ".jump_addr"},  hcif.jump_addr_o,            mon_e.ja);
      check_val({mon_tag, ".hold_flag"},  32'(hcif.hold_flag_o),       32'(mon_e.hf));
      check_val({mon_tag, ".flush"},      32'(hcif.flush_o),           32'(mon_e.fl));
      check_val({mon_tag, ".int_ack"},    32'(hcif.int_ack_o),         32'(mon_e.ack));
      check_val({mon_tag, ".halted"},     32'(hcif.jtag_halted_o),     32'(mon_e.hlt));
      check_val({mon_tag, ".reset_flag"}, 32'(hcif.jtag_reset_flag_o), 32'(mon_e.rf));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // Reset: outputs stay zero even with requests active.
    rst = 1'b1;
    drv(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    step("reset", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle();
    step("idle", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // EX jump, then jump requests ignored during the two flush cycles.
    drv(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step("jmp", 1'b1, 32'h100, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step("jmp_f1", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("jmp_f2", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    step("jmp_run", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Interrupt and EX jump together: interrupt wins, jump dropped.
    drv(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
    step("irq_jmp", 1'b1, 32'h200, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    step("irq_f1", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("irq_f2", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("irq_run", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Interrupt pulse during a 5-cycle EX hold; taken once the hold drops.
    drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h400);
    step("exh_irq", 1'b0, 32'h0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step("exh", 1'b0, 32'h0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    idle();
    step("exh_take", 1'b1, 32'h400, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("exh_f1", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("exh_f2", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("exh_run", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Bus stall merging.
    drv(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step("bus", 1'b0, 32'h0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step("bus_ex", 1'b0, 32'h0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    drv(1'b1, 32'h500, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step("bus_jmp", 1'b1, 32'h500, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step("bus_f1", 1'b0, 32'h0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    step("bus_f2", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("bus_run", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Debugger halt for 10 cycles; interrupt arriving while halted stays pending.
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    step("halt_req", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, (i == 5), 32'h600);
      step("halted", 1'b0, 32'h0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    idle();
    step("halt_rel", 1'b0, 32'h0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    step("halt_irq", 1'b1, 32'h600, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step("halt_f1", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("halt_f2", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("halt_run", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Debugger reset edge during FLUSH clears a pending interrupt.
    drv(1'b1, 32'h700, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step("jr_jmp", 1'b1, 32'h700, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h800);
    step("jr_f1_irq", 1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    step("jr_edge", 1'b0, 32'h0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    step("jr_r1", 1'b0, 32'h0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    step("jr_r2", 1'b0, 32'h0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    step("jr_run", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    step("jr_idle", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // New reset edge inside RESET restarts the count.
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    step("jr2_edge", 1'b0, 32'h0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    step("jr2_r1", 1'b0, 32'h0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    step("jr2_rest", 1'b0, 32'h0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    step("jr2_r1b", 1'b0, 32'h0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    step("jr2_r2b", 1'b0, 32'h0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    step("jr2_run", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    step("jr2_idle", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // rst pulsed mid-HALT with a bus stall active.
    drv(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step("hb_req", 1'b0, 32'h0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hb_halt", 1'b0, 32'h0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    drv(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step("rst_mid", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step("post_rst", 1'b0, 32'h0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    step("end_idle", 1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    check_val("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
